// File: rtl/bus_interface_unit.sv
// bus_interface_unit: multi-cycle T1/T2/T3 external memory bus controller.
// Define BIU_TIMEOUT_EN to abort T2 after TIMEOUT_CYCLES of ready low.
module bus_interface_unit #(
    parameter int AW             = 16,
    parameter int DW             = 8,
    parameter int WAIT_STATES    = 0,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          we,
    input  logic          addr_sel,
    input  logic [AW-1:0] pc_addr,
    input  logic [AW-1:0] hl_addr,
    input  logic [DW-1:0] wdata,
    input  logic          ready,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] instr,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] addr_bus,
    inout  wire  [DW-1:0] data_bus,
    output logic          rd_n,
    output logic          wr_n
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_T1,
        S_T2,
        S_T3
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          we_q;
    logic          sel_q;
    logic          oe_q;
    logic [DW-1:0] dout_q;
    logic [3:0]    wait_q;
    logic          accept;
    logic          sample;
    logic          timeout;
    logic          we_d;

    // new requests are only taken when no cycle is in flight
    assign accept = req && (state_q == S_IDLE || state_q == S_T3);
    assign sample = (state_q == S_T2) && (wait_q == 4'd0) && ready;
    assign we_d   = accept ? we : we_q;

    assign data_bus = oe_q ? dout_q : {DW{1'bz}};

`ifdef BIU_TIMEOUT_EN
    logic [15:0] to_q;

    assign timeout = (state_q == S_T2) && (wait_q == 4'd0) && !ready
                     && (to_q == 16'(TIMEOUT_CYCLES - 1));

    // count ready-low cycles once the wait states have run out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_q <= '0;
        end else if (state_q != S_T2 || wait_q != 4'd0 || ready) begin
            to_q <= '0;
        end else begin
            to_q <= to_q + 16'd1;
        end
    end

    // err flags an aborted cycle until the next request is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (accept) begin
            err <= 1'b0;
        end else if (timeout) begin
            err <= 1'b1;
        end
    end
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = TIMEOUT_CYCLES;
    assign timeout        = 1'b0;
    assign err            = 1'b0;
`endif

    // next-state decode of the bus cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (req) state_d = S_T1;
            S_T1:    state_d = S_T2;
            S_T2:    if (sample || timeout) state_d = S_T3;
            S_T3:    state_d = req ? S_T1 : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // state register and request latches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            sel_q    <= 1'b0;
            dout_q   <= '0;
            addr_bus <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q     <= we;
                sel_q    <= addr_sel;
                dout_q   <= wdata;
                addr_bus <= addr_sel ? hl_addr : pc_addr;
            end
        end
    end

    // wait-state counter: loaded in T1, drained in T2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q <= 4'd0;
        end else if (state_q == S_T1) begin
            wait_q <= 4'(WAIT_STATES);
        end else if (state_q == S_T2 && wait_q != 4'd0) begin
            wait_q <= wait_q - 4'd1;
        end
    end

    // capture read data into the fetch or data register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr <= '0;
            rdata <= '0;
        end else if (sample && !we_q) begin
            if (sel_q) begin
                rdata <= data_bus;
            end else begin
                instr <= data_bus;
            end
        end
    end

    // registered bus strobes and status derived from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            rd_n <= 1'b1;
            wr_n <= 1'b1;
            oe_q <= 1'b0;
        end else begin
            busy <= (state_d == S_T1) || (state_d == S_T2);
            done <= (state_d == S_T3);
            rd_n <= !((state_d == S_T2) && !we_d);
            wr_n <= !((state_d == S_T2) && we_d);
            oe_q <= we_d && (state_d != S_IDLE);
        end
    end

endmodule

// File: tb/tb_bus_interface_unit.sv
// tb_bus_interface_unit: scoreboard bench for bus_interface_unit.
// Main instance uses no wait states; a second instance uses two.
module tb_bus_interface_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic        addr_sel;
    logic [15:0] pc_addr;
    logic [15:0] hl_addr;
    logic [7:0]  wdata;
    logic        ready;
    logic [7:0]  mem_val;

    logic        busy, done, err, rd_n, wr_n;
    logic [7:0]  instr, rdata;
    logic [15:0] addr_bus;
    wire  [7:0]  data_bus;

    logic        w2_busy, w2_done, w2_err, w2_rd_n, w2_wr_n;
    logic [7:0]  w2_instr, w2_rdata;
    logic [15:0] w2_addr_bus;
    wire  [7:0]  data_bus2;

    int vec  = 0;
    int errs = 0;

    typedef struct {
        logic [7:0]  instr;
        logic [7:0]  rdata;
        logic [15:0] addr;
        logic        err;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] m_instr;
    logic [7:0] m_rdata;

    always #5 clk = ~clk;

    // memory model answers only while the read strobe is low
    assign data_bus  = rd_n ? 8'bz : mem_val;
    assign data_bus2 = w2_rd_n ? 8'bz : mem_val;

    bus_interface_unit #(
        .AW(16), .DW(8), .WAIT_STATES(0), .TIMEOUT_CYCLES(8)
    ) u_dut (
        .clk(clk), .rst(rst), .req(req), .we(we),
        .addr_sel(addr_sel), .pc_addr(pc_addr),
        .hl_addr(hl_addr), .wdata(wdata), .ready(ready),
        .busy(busy), .done(done), .err(err),
        .instr(instr), .rdata(rdata),
        .addr_bus(addr_bus), .data_bus(data_bus),
        .rd_n(rd_n), .wr_n(wr_n)
    );

    bus_interface_unit #(
        .AW(16), .DW(8), .WAIT_STATES(2), .TIMEOUT_CYCLES(8)
    ) u_ws2 (
        .clk(clk), .rst(rst), .req(req), .we(we),
        .addr_sel(addr_sel), .pc_addr(pc_addr),
        .hl_addr(hl_addr), .wdata(wdata), .ready(ready),
        .busy(w2_busy), .done(w2_done), .err(w2_err),
        .instr(w2_instr), .rdata(w2_rdata),
        .addr_bus(w2_addr_bus), .data_bus(data_bus2),
        .rd_n(w2_rd_n), .wr_n(w2_wr_n)
    );

    // both strobes low together is never legal
    always @(negedge clk) begin
        if (!rst && !rd_n && !wr_n) begin
            vec++;
            errs++;
            $display("FAIL strobes: rd_n=%b wr_n=%b both low", rd_n, wr_n);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic settle();
        req   = 1'b0;
        ready = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic issue(input logic w, input logic s,
                         input logic [15:0] a, input logic [7:0] d,
                         input logic [7:0] mv, input logic e,
                         input logic upd);
        exp_t x;
        we       = w;
        addr_sel = s;
        pc_addr  = s ? ~a : a;
        hl_addr  = s ? a : ~a;
        wdata    = d;
        mem_val  = mv;
        req      = 1'b1;
        if (!w && upd) begin
            if (s) m_rdata = mv;
            else   m_instr = mv;
        end
        x.instr = m_instr;
        x.rdata = m_rdata;
        x.addr  = a;
        x.err   = e;
        sbq.push_back(x);
    endtask

    task automatic wait_done(input int ready_at, output int lat,
                             output int rlo, output int wlo);
        lat = -1;
        rlo = 0;
        wlo = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (i == 1) req = 1'b0;
            if (i == ready_at) ready = 1'b1;
            if (!rd_n) rlo++;
            if (!wr_n) wlo++;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        req      = 1'b0;
        we       = 1'b0;
        addr_sel = 1'b0;
        pc_addr  = '0;
        hl_addr  = '0;
        wdata    = '0;
        ready    = 1'b1;
        mem_val  = '0;
        m_instr  = '0;
        m_rdata  = '0;
        #1;
        vec++;
        if ({busy, done, err} !== 3'b000) begin
            errs++;
            $display("FAIL reset_status: got %b want 000",
                     {busy, done, err});
        end
        vec++;
        if ({rd_n, wr_n} !== 2'b11) begin
            errs++;
            $display("FAIL reset_strobes: got %b want 11", {rd_n, wr_n});
        end
        vec++;
        if ({addr_bus, instr, rdata} !== 32'h0) begin
            errs++;
            $display("FAIL reset_regs: got %h want 0",
                     {addr_bus, instr, rdata});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fetch();
        int lat, rlo, wlo;
        exp_t e;
        settle();
        issue(1'b0, 1'b0, 16'h1234, 8'h00, 8'hA5, 1'b0, 1'b1);
        wait_done(0, lat, rlo, wlo);
        vec++;
        if (lat !== 3) begin
            errs++;
            $display("FAIL fetch_latency: got %0d want 3", lat);
        end
        if (lat < 0) return;
        e = sbq.pop_front();
        vec++;
        if (rlo !== 1 || wlo !== 0) begin
            errs++;
            $display("FAIL fetch_strobes: rd %0d wr %0d want 1 0",
                     rlo, wlo);
        end
        vec++;
        if (instr !== e.instr || rdata !== e.rdata) begin
            errs++;
            $display("FAIL fetch_data: got %h/%h want %h/%h",
                     instr, rdata, e.instr, e.rdata);
        end
        vec++;
        if (addr_bus !== e.addr || err !== e.err || busy !== 1'b0) begin
            errs++;
            $display("FAIL fetch_addr: got %h err %b busy %b want %h",
                     addr_bus, err, busy, e.addr);
        end
    endtask

    task automatic test_write_ws2();
        int lat, wlo, rlo;
        settle();
        we       = 1'b1;
        addr_sel = 1'b1;
        pc_addr  = 16'h0F0F;
        hl_addr  = 16'h8000;
        wdata    = 8'h3C;
        req      = 1'b1;
        lat = -1;
        wlo = 0;
        rlo = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
                req   = 1'b0;
                wdata = 8'hFF;
                we    = 1'b0;
            end
            if (!w2_wr_n) wlo++;
            if (!w2_rd_n) rlo++;
            if (w2_busy || w2_done) begin
                vec++;
                if (data_bus2 !== 8'h3C) begin
                    errs++;
                    $display("FAIL write_drive: cyc %0d got %h want 3c",
                             i, data_bus2);
                end
            end
            if (w2_done) begin
                lat = i;
                break;
            end
        end
        vec++;
        if (lat !== 5) begin
            errs++;
            $display("FAIL write_latency: got %0d want 5", lat);
        end
        vec++;
        if (wlo !== 3 || rlo !== 0) begin
            errs++;
            $display("FAIL write_strobes: wr %0d rd %0d want 3 0",
                     wlo, rlo);
        end
        vec++;
        if (w2_addr_bus !== 16'h8000 || w2_rdata !== 8'h00) begin
            errs++;
            $display("FAIL write_addr: got %h rdata %h want 8000 00",
                     w2_addr_bus, w2_rdata);
        end
        @(negedge clk);
        vec++;
        if (data_bus2 === 8'h3C || w2_done !== 1'b0) begin
            errs++;
            $display("FAIL write_release: bus %h done %b want z 0",
                     data_bus2, w2_done);
        end
    endtask

    task automatic test_ready_low();
        int lat, rlo, wlo;
        exp_t e;
        settle();
        ready = 1'b0;
        issue(1'b0, 1'b1, 16'h4321, 8'h00, 8'h5A, 1'b0, 1'b1);
        wait_done(6, lat, rlo, wlo);
        vec++;
        if (lat !== 7) begin
            errs++;
            $display("FAIL ready_latency: got %0d want 7", lat);
        end
        if (lat < 0) return;
        e = sbq.pop_front();
        vec++;
        if (rlo !== 5) begin
            errs++;
            $display("FAIL ready_strobe: rd low %0d want 5", rlo);
        end
        vec++;
        if (rdata !== e.rdata || instr !== e.instr) begin
            errs++;
            $display("FAIL ready_data: got %h/%h want %h/%h",
                     instr, rdata, e.instr, e.rdata);
        end
        mem_val = 8'h00;
        repeat (3) @(negedge clk);
        vec++;
        if (rdata !== e.rdata) begin
            errs++;
            $display("FAIL ready_hold: got %h want %h", rdata, e.rdata);
        end
    endtask

    task automatic test_back_to_back();
        int last, n;
        exp_t e;
        settle();
        issue(1'b0, 1'b0, 16'h0200, 8'h00, 8'h30, 1'b0, 1'b1);
        last = 0;
        n    = 0;
        for (int i = 1; i <= 80 && n < 6; i++) begin
            @(negedge clk);
            if (done) begin
                e = sbq.pop_front();
                vec++;
                if (instr !== e.instr || rdata !== e.rdata ||
                    addr_bus !== e.addr) begin
                    errs++;
                    $display("FAIL b2b_data%0d: got %h/%h @%h want %h/%h @%h",
                             n, instr, rdata, addr_bus,
                             e.instr, e.rdata, e.addr);
                end
                if (n > 0) begin
                    vec++;
                    if (i - last !== 3) begin
                        errs++;
                        $display("FAIL b2b_gap%0d: got %0d want 3",
                                 n, i - last);
                    end
                end
                last = i;
                n++;
                if (n < 6) begin
                    issue(1'b0, n[0], 16'h0200 + 16'(n), 8'h00,
                          8'h30 + 8'(n), 1'b0, 1'b1);
                end else begin
                    req = 1'b0;
                end
            end
        end
        vec++;
        if (n !== 6) begin
            errs++;
            $display("FAIL b2b_count: got %0d dones want 6", n);
        end
        req = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        int lat, rlo, wlo;
        exp_t e;
        settle();
        ready = 1'b0;
        we       = 1'b1;
        addr_sel = 1'b0;
        pc_addr  = 16'h0040;
        wdata    = 8'h77;
        req      = 1'b1;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        vec++;
        if (wr_n !== 1'b0 || data_bus !== 8'h77) begin
            errs++;
            $display("FAIL rst_pre: wr_n %b bus %h want 0 77",
                     wr_n, data_bus);
        end
        #2 rst = 1'b1;
        #1;
        vec++;
        if (wr_n !== 1'b1 || busy !== 1'b0 || data_bus === 8'h77) begin
            errs++;
            $display("FAIL rst_async: wr_n %b busy %b bus %h",
                     wr_n, busy, data_bus);
        end
        #1 rst = 1'b0;
        sbq.delete();
        m_instr = '0;
        m_rdata = '0;
        ready = 1'b1;
        @(negedge clk);
        issue(1'b0, 1'b0, 16'h0100, 8'h00, 8'h9E, 1'b0, 1'b1);
        wait_done(0, lat, rlo, wlo);
        vec++;
        if (lat !== 3) begin
            errs++;
            $display("FAIL rst_next_latency: got %0d want 3", lat);
        end
        if (lat < 0) return;
        e = sbq.pop_front();
        vec++;
        if (instr !== e.instr || rdata !== e.rdata ||
            addr_bus !== e.addr) begin
            errs++;
            $display("FAIL rst_next_data: got %h/%h @%h want %h/%h @%h",
                     instr, rdata, addr_bus, e.instr, e.rdata, e.addr);
        end
    endtask

`ifdef BIU_TIMEOUT_EN
    task automatic test_timeout();
        int lat, rlo, wlo;
        exp_t e;
        settle();
        ready = 1'b0;
        issue(1'b0, 1'b1, 16'h5555, 8'h00, 8'hEE, 1'b1, 1'b0);
        wait_done(0, lat, rlo, wlo);
        vec++;
        if (lat !== 10) begin
            errs++;
            $display("FAIL timeout_latency: got %0d want 10", lat);
        end
        if (lat < 0) return;
        e = sbq.pop_front();
        vec++;
        if (err !== e.err || rdata !== e.rdata || instr !== e.instr) begin
            errs++;
            $display("FAIL timeout_flags: err %b data %h/%h want %b %h/%h",
                     err, instr, rdata, e.err, e.instr, e.rdata);
        end
        settle();
        issue(1'b0, 1'b1, 16'h5556, 8'h00, 8'h66, 1'b0, 1'b1);
        wait_done(0, lat, rlo, wlo);
        e = sbq.pop_front();
        vec++;
        if (err !== e.err || rdata !== e.rdata) begin
            errs++;
            $display("FAIL timeout_clear: err %b rdata %h want %b %h",
                     err, rdata, e.err, e.rdata);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fetch();
        test_write_ws2();
        test_ready_low();
        test_back_to_back();
        test_reset_mid_write();
`ifdef BIU_TIMEOUT_EN
        test_timeout();
`endif
        settle();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
